// File: rtl/div_defs.sv
// Shared definitions for the sequential divider: state encodings and result constants.
package div_defs;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;
    localparam logic [DIV_WIDTH-1:0] DBZ_QUOT = {DIV_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_ITER  = 2'd2,
        S_FIX   = 2'd3
    } state_t;

endpackage

// File: rtl/sub33_borrow.sv
// Combinational subtractor built as a + ~b + 1; borrow is the inverted carry out.
module sub33_borrow #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    logic [W:0] sum;

    assign sum    = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
    assign diff   = sum[W-1:0];
    assign borrow = ~sum[W];

endmodule

// File: rtl/seq_div32.sv
// Multi-cycle restoring divider: one quotient bit per cycle through a shared subtractor,
// with sign handling on either side of the unsigned magnitude loop.
module seq_div32
    import div_defs::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_q;       // dividend, then shifted into the quotient
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] p_q;       // partial remainder
    logic             signed_q;
    logic             sign_q;
    logic             sign_r;
    logic             dbz_pend;
    logic             accept;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             sub_borrow;
    logic             q_bit;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    assign shifted = {p_q, a_q[WIDTH-1]};

    sub33_borrow #(.W(WIDTH + 1)) u_sub (
        .a      (shifted),
        .b      ({1'b0, d_q}),
        .diff   (trial),
        .borrow (sub_borrow)
    );

    // A kept difference must also fit the WIDTH-bit remainder register.
    assign q_bit = ~sub_borrow & ~trial[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (divisor == '0) ? S_FIX : S_SETUP;
            S_SETUP: state_nxt = S_ITER;
            S_ITER:  if (cnt == CNT_W'(WIDTH - 1)) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        accept = 1'b0;
        busy   = 1'b0;
        if (state == S_IDLE) accept = start;
        else                 busy   = ~dbz_pend;
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            a_q       <= '0;
            d_q       <= '0;
            p_q       <= '0;
            signed_q  <= 1'b0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            dbz_pend  <= 1'b0;
            done      <= 1'b0;
            dbz       <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_q      <= dividend;
                        d_q      <= divisor;
                        signed_q <= is_signed;
                        dbz_pend <= (divisor == '0);
                        dbz      <= 1'b0;
                    end
                end
                S_SETUP: begin
                    if (signed_q && a_q[WIDTH-1]) a_q <= negate(a_q);
                    if (signed_q && d_q[WIDTH-1]) d_q <= negate(d_q);
                    sign_q <= signed_q & (a_q[WIDTH-1] ^ d_q[WIDTH-1]);
                    sign_r <= signed_q & a_q[WIDTH-1];
                    p_q    <= '0;
                    cnt    <= '0;
                end
                S_ITER: begin
                    a_q <= {a_q[WIDTH-2:0], q_bit};
                    p_q <= q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                    cnt <= cnt + CNT_W'(1);
                end
                S_FIX: begin
                    done <= 1'b1;
                    if (dbz_pend) begin
                        dbz       <= 1'b1;
                        quotient  <= DBZ_QUOT;
                        remainder <= a_q;
                    end else begin
                        quotient  <= sign_q ? negate(a_q) : a_q;
                        remainder <= sign_r ? negate(p_q) : p_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
